// File: rtl/ps2_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_event_ctrl
//
// Turns the PS/2 scan-code byte stream into printable characters for the LCD
// writer. Break (F0) and extended (E0) prefixes are stripped. Typematic
// repeats of the held key are suppressed. Each new make code is registered
// onto lookup_code, which drives an external combinational keycode-to-ASCII
// table. One cycle later the table result is pushed into a small character
// FIFO. The FIFO is read through a valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH     character FIFO entries (power of 2, >= 2)
//   DROP_UNMAPPED  1: lookup results equal to 8'h2E ('.', the table default
//                  for unmapped codes) are discarded instead of queued
//
// Optional feature (macro KEY_LOWERCASE_EN)
//   Left shift (12) and right shift (59) are tracked as independent flags.
//   Letters A..Z are queued in lowercase unless a shift key is held.
//   Without the macro, 12/59 are ordinary codes and letters stay uppercase.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   scan_code     byte from the PS/2 receiver
//   scan_valid    one-cycle strobe qualifying scan_code
//   lookup_code   registered keycode driven into the ASCII lookup
//   lookup_ascii  combinational lookup result for lookup_code
//   char_data     FIFO head character (0 while empty)
//   char_valid    FIFO non-empty
//   char_ready    consumer accepts char_data when char_valid && char_ready
//   fifo_count    current FIFO occupancy
//   overflow      sticky: a character was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter bit DROP_UNMAPPED = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  scan_code,
    input  logic                        scan_valid,
    output logic [7:0]                  lookup_code,
    input  logic [7:0]                  lookup_ascii,
    output logic [7:0]                  char_data,
    output logic                        char_valid,
    input  logic                        char_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [7:0] CODE_BREAK     = 8'hF0;
    localparam logic [7:0] CODE_EXT       = 8'hE0;
    localparam logic [7:0] ASCII_UNMAPPED = 8'h2E;
`ifdef KEY_LOWERCASE_EN
    localparam logic [7:0] CODE_LSHIFT    = 8'h12;
    localparam logic [7:0] CODE_RSHIFT    = 8'h59;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_t;

    state_t state_reg, state_next;

    logic [7:0] held_code_reg;
    logic       held_valid_reg;
    logic [7:0] lookup_code_reg;
    logic       lookup_pending_reg;

    // Decoder actions for the current scan byte
    logic make_load;
    logic held_release;

`ifdef KEY_LOWERCASE_EN
    logic lshift_reg, rshift_reg;
    logic lshift_set, lshift_clr, rshift_set, rshift_clr;
`endif

    // FIFO storage and control
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [7:0]    char_data_reg, char_data_next;
    logic          overflow_reg;

    logic [7:0] push_data;
    logic       push_req, pop, full, do_write, drop;

    // -----------------------------------------------------------------------
    // Prefix / make decoder
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        make_load    = 1'b0;
        held_release = 1'b0;
`ifdef KEY_LOWERCASE_EN
        lshift_set   = 1'b0;
        lshift_clr   = 1'b0;
        rshift_set   = 1'b0;
        rshift_clr   = 1'b0;
`endif
        if (scan_valid) begin
            case (state_reg)
                S_IDLE: begin
                    if (scan_code == CODE_BREAK) begin
                        state_next = S_BREAK;
                    end else if (scan_code == CODE_EXT) begin
                        state_next = S_EXT;
`ifdef KEY_LOWERCASE_EN
                    end else if (scan_code == CODE_LSHIFT) begin
                        lshift_set = 1'b1;
                    end else if (scan_code == CODE_RSHIFT) begin
                        rshift_set = 1'b1;
`endif
                    end else if (held_valid_reg && scan_code == held_code_reg) begin
                        // Typematic repeat of the key already held: ignore
                        make_load = 1'b0;
                    end else begin
                        make_load = 1'b1;
                    end
                end
                S_BREAK: begin
                    if (scan_code == held_code_reg) begin
                        held_release = 1'b1;
                    end
`ifdef KEY_LOWERCASE_EN
                    lshift_clr = (scan_code == CODE_LSHIFT);
                    rshift_clr = (scan_code == CODE_RSHIFT);
`endif
                    state_next = S_IDLE;
                end
                S_EXT: begin
                    // Extended keys have no printable mapping
                    state_next = (scan_code == CODE_BREAK) ? S_EXT_BREAK : S_IDLE;
                end
                S_EXT_BREAK: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_code_reg      <= 8'h00;
            held_valid_reg     <= 1'b0;
            lookup_code_reg    <= 8'h00;
            lookup_pending_reg <= 1'b0;
        end else begin
            if (make_load) begin
                held_code_reg   <= scan_code;
                held_valid_reg  <= 1'b1;
                lookup_code_reg <= scan_code;
            end else if (held_release) begin
                held_valid_reg  <= 1'b0;
            end
            // The lookup result is consumed exactly one cycle after the load.
            // A back-to-back make simply re-arms it with the new code.
            lookup_pending_reg <= make_load;
        end
    end

`ifdef KEY_LOWERCASE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lshift_reg <= 1'b0;
            rshift_reg <= 1'b0;
        end else begin
            if (lshift_set) begin
                lshift_reg <= 1'b1;
            end else if (lshift_clr) begin
                lshift_reg <= 1'b0;
            end
            if (rshift_set) begin
                rshift_reg <= 1'b1;
            end else if (rshift_clr) begin
                rshift_reg <= 1'b0;
            end
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Character shaping
    // -----------------------------------------------------------------------
    always_comb begin
        push_data = lookup_ascii;
`ifdef KEY_LOWERCASE_EN
        if (lookup_ascii >= 8'h41 && lookup_ascii <= 8'h5A && !(lshift_reg || rshift_reg)) begin
            push_data = lookup_ascii + 8'h20;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Character FIFO
    // -----------------------------------------------------------------------
    always_comb begin
        pop      = (count_reg != '0) && char_ready;
        full     = (count_reg == DEPTH_C);
        push_req = lookup_pending_reg && !(DROP_UNMAPPED && lookup_ascii == ASCII_UNMAPPED);
        // A full FIFO still accepts a push if the head leaves in the same cycle
        do_write = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        rd_ptr_next = pop      ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        wr_ptr_next = do_write ? wr_ptr_reg + AW'(1) : wr_ptr_reg;

        count_next = count_reg;
        if (do_write && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!do_write && pop) begin
            count_next = count_reg - CW'(1);
        end

        // char_data is registered. The head after this edge is the entry
        // being written now whenever the new read pointer lands on the write
        // slot (push into empty, or push+pop with a single entry).
        if (count_next == '0) begin
            char_data_next = 8'h00;
        end else if (do_write && rd_ptr_next == wr_ptr_reg) begin
            char_data_next = push_data;
        end else begin
            char_data_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            char_data_reg <= 8'h00;
            overflow_reg  <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            char_data_reg <= char_data_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign lookup_code = lookup_code_reg;
    assign char_data   = char_data_reg;
    assign char_valid  = (count_reg != '0);
    assign fifo_count  = count_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_ctrl
//
// Two instances share one stimulus stream: dut0 drops unmapped lookups,
// dut1 queues them. A behavioural model (prefix flags, held key, and a
// plain list per FIFO) is compared against both instances on every falling
// edge. On top of that there is a table of directed vectors, a set of
// hand-written multi-cycle sequences, and a randomized run.
// Build with +define+KEY_LOWERCASE_EN to exercise the lowercase feature.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
`ifdef KEY_LOWERCASE_EN
    localparam bit         SHIFT_EN = 1'b1;
    localparam logic [7:0] ACH = 8'h61;
    localparam logic [7:0] BCH = 8'h62;
`else
    localparam bit         SHIFT_EN = 1'b0;
    localparam logic [7:0] ACH = 8'h41;
    localparam logic [7:0] BCH = 8'h42;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       char_ready = 1'b0;

    logic [7:0] lk0, lk1, la0, la1, cd0, cd1;
    logic       cv0, cv1, ovf0, ovf1;
    logic [2:0] cnt0, cnt1;

    always #5 clk = ~clk;

    // Keycode-to-ASCII table seen by the DUT
    function automatic logic [7:0] lut(input logic [7:0] c);
        case (c)
            8'h1C:   return 8'h41;
            8'h32:   return 8'h42;
            8'h16:   return 8'h31;
            8'h1E:   return 8'h32;
            8'h26:   return 8'h33;
            8'h25:   return 8'h34;
            8'h2E:   return 8'h35;
            default: return 8'h2E;
        endcase
    endfunction

    assign la0 = lut(lk0);
    assign la1 = lut(lk1);

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .DROP_UNMAPPED(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .lookup_code(lk0), .lookup_ascii(la0), .char_data(cd0), .char_valid(cv0),
        .char_ready(char_ready), .fifo_count(cnt0), .overflow(ovf0));

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .DROP_UNMAPPED(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .lookup_code(lk1), .lookup_ascii(la1), .char_data(cd1), .char_valid(cv1),
        .char_ready(char_ready), .fifo_count(cnt1), .overflow(ovf1));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit verbose  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit         m_brk, m_ext, m_held_v, m_ls, m_rs, m_pend;
    logic [7:0] m_held, m_lk;
    logic [7:0] m_buf [2][DEPTH];
    int         m_cnt [2];
    bit         m_ovf [2];

    function automatic logic [7:0] shape(input logic [7:0] a, input bit shifted);
        if (SHIFT_EN && a >= 8'h41 && a <= 8'h5A && !shifted) return a + 8'h20;
        return a;
    endfunction

    task automatic model_step();
        bit pop, pushing, was_full;
        logic [7:0] ch;
        if (reset) begin
            m_brk = 0; m_ext = 0; m_held_v = 0; m_ls = 0; m_rs = 0; m_pend = 0;
            m_held = 8'h00; m_lk = 8'h00;
            for (int m = 0; m < 2; m++) begin m_cnt[m] = 0; m_ovf[m] = 0; end
            return;
        end
        for (int m = 0; m < 2; m++) begin
            pop      = (m_cnt[m] > 0) && char_ready;
            pushing  = m_pend && !(m == 0 && lut(m_lk) == 8'h2E);
            was_full = (m_cnt[m] == DEPTH);
            ch       = shape(lut(m_lk), m_ls || m_rs);
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) m_buf[m][i] = m_buf[m][i+1];
                m_cnt[m]--;
            end
            if (pushing) begin
                if (was_full && !pop) m_ovf[m] = 1;
                else begin m_buf[m][m_cnt[m]] = ch; m_cnt[m]++; end
            end
        end
        m_pend = 0;
        if (scan_valid) begin
            if (m_ext && m_brk) begin
                m_ext = 0; m_brk = 0;
            end else if (m_ext) begin
                if (scan_code == 8'hF0) m_brk = 1; else m_ext = 0;
            end else if (m_brk) begin
                m_brk = 0;
                if (scan_code == m_held) m_held_v = 0;
                if (SHIFT_EN && scan_code == 8'h12) m_ls = 0;
                if (SHIFT_EN && scan_code == 8'h59) m_rs = 0;
            end else if (scan_code == 8'hF0) m_brk = 1;
            else if (scan_code == 8'hE0) m_ext = 1;
            else if (SHIFT_EN && scan_code == 8'h12) m_ls = 1;
            else if (SHIFT_EN && scan_code == 8'h59) m_rs = 1;
            else if (m_held_v && scan_code == m_held) begin
                m_pend = 0;
            end else begin
                m_held = scan_code; m_held_v = 1; m_lk = scan_code; m_pend = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("dut0 lookup_code", {24'd0, lk0}, {24'd0, m_lk});
            check("dut1 lookup_code", {24'd0, lk1}, {24'd0, m_lk});
            check("dut0 char_valid", {31'd0, cv0}, {31'd0, m_cnt[0] > 0});
            check("dut1 char_valid", {31'd0, cv1}, {31'd0, m_cnt[1] > 0});
            check("dut0 char_data", {24'd0, cd0}, {24'd0, (m_cnt[0] > 0) ? m_buf[0][0] : 8'h00});
            check("dut1 char_data", {24'd0, cd1}, {24'd0, (m_cnt[1] > 0) ? m_buf[1][0] : 8'h00});
            check("dut0 fifo_count", {29'd0, cnt0}, 32'(m_cnt[0]));
            check("dut1 fifo_count", {29'd0, cnt1}, 32'(m_cnt[1]));
            check("dut0 overflow", {31'd0, ovf0}, {31'd0, m_ovf[0]});
            check("dut1 overflow", {31'd0, ovf1}, {31'd0, m_ovf[1]});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] got0[$];
    logic [7:0] got1[$];

    task automatic step(input logic v, input logic [7:0] c);
        scan_valid = v;
        scan_code  = c;
        // Characters accepted at the coming edge
        if (cv0 && char_ready) begin
            got0.push_back(cd0);
            if (verbose) $display("dut0 char %02h", cd0);
        end
        if (cv1 && char_ready) begin
            got1.push_back(cd1);
            if (verbose) $display("dut1 char %02h", cd1);
        end
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        got0.delete();
        got1.delete();
    endtask

    typedef struct {
        logic       rdy;
        logic       v;
        logic [7:0] code;
        logic [7:0] e_lk;
        logic       e_cv;
        logic [7:0] e_cd;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl [14];
    logic [7:0] rand_codes [12];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 8'h1C, 8'h1C, 1'b0, 8'h00, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 8'h1C, 1'b1, ACH,   3'd1};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'h1C, 1'b0, 8'h00, 3'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'h1C, 8'h1C, 1'b0, 8'h00, 3'd0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'h1C, 1'b0, 8'h00, 3'd0};
        tbl[5]  = '{1'b0, 1'b1, 8'hF0, 8'h1C, 1'b0, 8'h00, 3'd0};
        tbl[6]  = '{1'b0, 1'b1, 8'h1C, 8'h1C, 1'b0, 8'h00, 3'd0};
        tbl[7]  = '{1'b0, 1'b1, 8'h1C, 8'h1C, 1'b0, 8'h00, 3'd0};
        tbl[8]  = '{1'b0, 1'b1, 8'h1C, 8'h1C, 1'b1, ACH,   3'd1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 8'h1C, 1'b1, ACH,   3'd1};
        tbl[10] = '{1'b0, 1'b1, 8'h32, 8'h32, 1'b1, ACH,   3'd1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h32, 1'b1, ACH,   3'd2};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 8'h32, 1'b1, BCH,   3'd1};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 8'h32, 1'b0, 8'h00, 3'd0};
        rand_codes = '{8'h1C, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                       8'h0E, 8'hF0, 8'hE0, 8'h12, 8'h59, 8'h75};

        // ---- reset values ----
        do_reset();
        check("reset lookup_code", {24'd0, lk0}, 32'h0);
        check("reset char_valid", {31'd0, cv0}, 32'h0);
        check("reset char_data", {24'd0, cd0}, 32'h0);
        check("reset fifo_count", {29'd0, cnt0}, 32'h0);
        check("reset overflow", {31'd0, ovf0}, 32'h0);
        chk_en = 1'b1;

        // ---- table-driven vectors: latency, typematic, stable head ----
        for (int i = 0; i < 14; i++) begin
            char_ready = tbl[i].rdy;
            step(tbl[i].v, tbl[i].code);
            check($sformatf("vec%0d lookup_code", i), {24'd0, lk0}, {24'd0, tbl[i].e_lk});
            check($sformatf("vec%0d char_valid", i), {31'd0, cv0}, {31'd0, tbl[i].e_cv});
            check($sformatf("vec%0d char_data", i), {24'd0, cd0}, {24'd0, tbl[i].e_cd});
            check($sformatf("vec%0d fifo_count", i), {29'd0, cnt0}, {29'd0, tbl[i].e_cnt});
        end

        // ---- extended prefixes are swallowed ----
        do_reset();
        char_ready = 1'b1;
        step(1, 8'hE0); step(1, 8'h75); step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h75);
        step(1, 8'h16);
        idle(4);
        check("ext count", got0.size(), 32'd1);
        check("ext char", {24'd0, (got0.size() > 0) ? got0[0] : 8'h00}, 32'h31);
        step(1, 8'h1E);
        idle(4);
        check("ext idle-after count", got0.size(), 32'd2);
        check("ext idle-after char", {24'd0, (got0.size() > 1) ? got0[1] : 8'h00}, 32'h32);

        // ---- overflow with a stalled consumer ----
        do_reset();
        char_ready = 1'b0;
        foreach (rand_codes[k]) begin
            if (k >= 1 && k <= 5) begin
                step(1, rand_codes[k]); step(1, 8'hF0); step(1, rand_codes[k]);
            end
        end
        idle(3);
        check("ovf fifo_count", {29'd0, cnt0}, 32'd4);
        check("ovf overflow", {31'd0, ovf0}, 32'd1);
        check("ovf head", {24'd0, cd0}, 32'h31);
        char_ready = 1'b1;
        got0.delete();
        idle(6);
        check("ovf drain count", got0.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("ovf drain %0d", i),
                  {24'd0, (got0.size() > i) ? got0[i] : 8'h00}, 32'h31 + i);
        check("ovf sticky", {31'd0, ovf0}, 32'd1);
        check("ovf empty", {29'd0, cnt0}, 32'd0);

        // ---- unmapped code ----
        do_reset();
        char_ready = 1'b1;
        step(1, 8'h0E);
        idle(4);
        check("unmapped drop", got0.size(), 32'd0);
        check("unmapped keep count", got1.size(), 32'd1);
        check("unmapped keep char", {24'd0, (got1.size() > 0) ? got1[0] : 8'h00}, 32'h2E);

        // ---- back-to-back makes ----
        do_reset();
        char_ready = 1'b1;
        step(1, 8'h16); step(1, 8'h1E); step(1, 8'h26);
        idle(4);
        check("b2b count", got0.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b char %0d", i),
                  {24'd0, (got0.size() > i) ? got0[i] : 8'h00}, 32'h31 + i);

        // ---- reset in the middle of a break sequence ----
        do_reset();
        char_ready = 1'b0;
        step(1, 8'h1C);
        idle(2);
        step(1, 8'hF0);
        reset = 1'b1;
        step(0, 8'h00);
        reset = 1'b0;
        check("midreset count", {29'd0, cnt0}, 32'd0);
        check("midreset valid", {31'd0, cv0}, 32'd0);
        char_ready = 1'b1;
        got0.delete();
        step(1, 8'h1C);
        idle(3);
        check("midreset emit count", got0.size(), 32'd1);
        check("midreset emit char", {24'd0, (got0.size() > 0) ? got0[0] : 8'h00}, {24'd0, ACH});

`ifdef KEY_LOWERCASE_EN
        // ---- shift handling ----
        do_reset();
        char_ready = 1'b1;
        step(1, 8'h1C); step(1, 8'hF0); step(1, 8'h1C);
        step(1, 8'h12); step(1, 8'h1C);
        step(1, 8'hF0); step(1, 8'h12); step(1, 8'hF0); step(1, 8'h1C);
        step(1, 8'h1C);
        idle(4);
        check("shift count", got0.size(), 32'd3);
        check("shift c0", {24'd0, (got0.size() > 0) ? got0[0] : 8'h00}, 32'h61);
        check("shift c1", {24'd0, (got0.size() > 1) ? got0[1] : 8'h00}, 32'h41);
        check("shift c2", {24'd0, (got0.size() > 2) ? got0[2] : 8'h00}, 32'h61);
`endif

        // ---- randomized run against the model ----
        verbose = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            char_ready = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 1) == 1, rand_codes[$urandom_range(0, 11)]);
        end
        reset = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
